// File: rtl/ysyx_25040105_pkg.sv
// ============================================================================
// Module : ysyx_25040105_pkg
// Brief  : Shared types and constants for the prefetching instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_25040105_pkg;

    localparam int unsigned IFU_XLEN = 32;
    localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [31:0]         inst;
        logic                err;
    } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_25040105_fifo.sv
// ============================================================================
// Module : ysyx_25040105_fifo
// Brief  : Synchronous power-of-two FIFO with flush; flush beats push and pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_25040105_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_push;
    logic             w_pop;

    assign full   = (count_q == CNT_FULL);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rd_ptr_q];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040105_ifu_prefetch.sv
// ============================================================================
// Module : ysyx_25040105_ifu_prefetch
// Brief  : Single-outstanding fetch engine feeding a prefetch FIFO, with flush on redirect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_25040105_ifu_prefetch
    import ysyx_25040105_pkg::*;
#(
    parameter int unsigned         XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0]     RESET_PC = IFU_RESET_PC,
    parameter int unsigned         DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_data,
    input  logic            rsp_err,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    input  logic            inst_ready,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned   CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_CAP  = DEPTH[CW-1:0];
    localparam logic [XLEN-1:0] PC_STEP = 4;

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;

    ifq_entry_t      w_entry;
    ifq_entry_t      w_head;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic            w_req_hs;
    logic            w_push;
    logic            w_pop;
    logic            w_inflight;
    logic            w_unused_ok;

    // A request is only issued when the FIFO can hold its eventual response.
    assign req_valid  = !rst && (state_q == ST_FETCH) && (w_count < CNT_CAP);
    assign req_addr   = fetch_pc_q;
    assign w_req_hs   = req_valid && req_ready;
    assign w_push     = (state_q == ST_WAIT) && rsp_valid;
    assign w_pop      = inst_valid && inst_ready;
    assign w_inflight = w_req_hs || ((state_q != ST_FETCH) && !rsp_valid);

    assign w_entry.pc   = fetch_pc_q - PC_STEP;
    assign w_entry.inst = rsp_data;
    assign w_entry.err  = rsp_err;

    assign inst_valid = !w_empty;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign inst_err   = w_head.err;

    assign w_unused_ok = ^{redirect_pc[1:0], w_full};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
        end else if (redirect_en) begin
            fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            state_q    <= w_inflight ? ST_DROP : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (w_req_hs) begin
                        fetch_pc_q <= fetch_pc_q + PC_STEP;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT, ST_DROP: begin
                    if (rsp_valid) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    ysyx_25040105_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_ifq (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_en),
        .wdata (w_entry),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040105_ifu_prefetch.sv
// ============================================================================
// Module : tb_ysyx_25040105_ifu_prefetch
// Brief  : Self-checking bench: vector table, directed corner sequences, random traffic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040105_ifu_prefetch;

    localparam logic [31:0] B = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_ready = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;

    ysyx_25040105_ifu_prefetch #(
        .XLEN     (32),
        .RESET_PC (B),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_err    (inst_err),
        .inst_ready  (inst_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: architectural fetch stream plus a one-outstanding memory.
    logic [31:0] exp_req, exp_pc, mem_addr, first_pc;
    bit          mem_busy, redir_last, zw;
    int          mem_lat, cyc, last_pop, npops, nrsp;

    function automatic logic [31:0] memd(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic memerr(input logic [31:0] a);
        return a[5:2] == 4'd2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_err = 0;
        inst_ready = 0; redirect_en = 0; redirect_pc = '0;
        #1;
        chk1("rst_req_valid", req_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_req = B; exp_pc = B; mem_busy = 0; redir_last = 0;
        last_pop = -1; cyc = 0;
    endtask

    // One clock of traffic: drive, check at negedge, advance the model after posedge.
    task automatic step(input bit rdy, input bit ir, input bit rd, input logic [31:0] rpc, input int lat);
        bit          hs;
        logic [31:0] haddr;
        req_ready = rdy; inst_ready = ir; redirect_en = rd; redirect_pc = rpc;
        @(negedge clk);
        cyc++;
        if (redir_last) chk1("flush_inst_valid", inst_valid, 1'b0);
        hs = req_valid && req_ready;
        haddr = req_addr;
        if (hs) begin
            chk1("one_outstanding", mem_busy, 1'b0);
            chk("req_addr", req_addr, exp_req);
            exp_req = exp_req + 32'd4;
        end
        if (inst_valid && inst_ready && !redirect_en) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, memd(exp_pc));
            chk1("inst_err", inst_err, memerr(exp_pc));
            if (npops == 0) first_pc = inst_pc;
            if (zw && last_pop >= 0) chk("pop_gap", cyc - last_pop, 2);
            last_pop = cyc;
            npops++;
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_en) begin
            exp_pc  = {rpc[31:2], 2'b00};
            exp_req = {rpc[31:2], 2'b00};
        end
        redir_last = redirect_en;
        @(posedge clk);
        #1;
        if (rsp_valid) begin
            rsp_valid = 0; mem_busy = 0; nrsp++;
        end
        if (hs) begin
            mem_busy = 1; mem_addr = haddr; mem_lat = lat;
        end
        if (mem_busy && !rsp_valid) begin
            if (mem_lat == 0) begin
                rsp_valid = 1; rsp_data = memd(mem_addr); rsp_err = memerr(mem_addr);
            end else begin
                mem_lat--;
            end
        end
    endtask

    typedef struct {
        bit          rr;
        bit          rv;
        logic [31:0] rpc;
        bit          ir;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
        bit          e_err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        tbl[0]  = '{1, 0, B,      0, 1, B,      0, B,      0};
        tbl[1]  = '{1, 1, B,      0, 0, B+4,    0, B,      0};
        tbl[2]  = '{1, 0, B,      0, 1, B+4,    1, B,      0};
        tbl[3]  = '{1, 1, B+4,    0, 0, B+8,    1, B,      0};
        tbl[4]  = '{1, 0, B,      0, 1, B+8,    1, B,      0};
        tbl[5]  = '{1, 1, B+8,    0, 0, B+12,   1, B,      0};
        tbl[6]  = '{1, 0, B,      0, 1, B+12,   1, B,      0};
        tbl[7]  = '{1, 1, B+12,   0, 0, B+16,   1, B,      0};
        tbl[8]  = '{1, 0, B,      0, 0, B+16,   1, B,      0};
        tbl[9]  = '{1, 0, B,      0, 0, B+16,   1, B,      0};
        tbl[10] = '{1, 0, B,      1, 0, B+16,   1, B,      0};
        tbl[11] = '{1, 0, B,      1, 1, B+16,   1, B+4,    0};
        tbl[12] = '{0, 1, B+16,   1, 0, B+20,   1, B+8,    1};
        tbl[13] = '{0, 0, B,      1, 1, B+20,   1, B+12,   0};
        tbl[14] = '{0, 0, B,      1, 1, B+20,   1, B+16,   0};
        tbl[15] = '{0, 0, B,      0, 1, B+20,   0, B,      0};

        // Vector table: fill to DEPTH with the decoder stalled, then drain.
        do_reset();
        chk1("reset_inst_valid", inst_valid, 1'b0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_inst_pc", inst_pc, 32'h0);
        for (int i = 0; i < 16; i++) begin
            req_ready = tbl[i].rr; rsp_valid = tbl[i].rv;
            rsp_data = memd(tbl[i].rpc); rsp_err = memerr(tbl[i].rpc);
            inst_ready = tbl[i].ir;
            @(negedge clk);
            chk1($sformatf("tbl%0d_req_valid", i), req_valid, tbl[i].e_rv);
            chk($sformatf("tbl%0d_req_addr", i), req_addr, tbl[i].e_addr);
            chk1($sformatf("tbl%0d_inst_valid", i), inst_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) begin
                chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), inst, memd(tbl[i].e_pc));
                chk1($sformatf("tbl%0d_inst_err", i), inst_err, tbl[i].e_err);
            end
            @(posedge clk);
            #1;
        end
        rsp_valid = 0;

        // Zero-wait memory: one instruction every second cycle.
        do_reset();
        npops = 0; zw = 1;
        repeat (24) step(1, 1, 0, '0, 0);
        zw = 0;
        chk("zw_pops", npops, 11);

        // Redirect one cycle after the handshake with a 3-cycle memory.
        do_reset();
        npops = 0;
        step(1, 1, 0, '0, 2);
        step(1, 1, 1, 32'h8000_0100, 2);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1, 1, 0, '0, 2);
            found = (npops > 0);
        end
        chk1("redir_pop_seen", found, 1'b1);
        chk("redir_first_pc", first_pc, 32'h8000_0100);

        // Redirect coinciding with a push and a pop, then refill must take DEPTH entries.
        do_reset();
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(1, 1, 1, 32'h8000_0200, 0);
        nrsp = 0;
        repeat (16) step(1, 0, 0, '0, 0);
        chk("refill_responses", nrsp, 4);
        chk1("refill_stall", req_valid, 1'b0);
        npops = 0;
        repeat (12) step(1, 1, 0, '0, 0);
        chk("refill_first_pc", first_pc, 32'h8000_0200);

        // Asynchronous reset while a fetch is outstanding.
        do_reset();
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 3);
        step(0, 0, 0, '0, 3);
        chk1("pre_rst_inst_valid", inst_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_req_valid", req_valid, 1'b0);
        chk1("async_rst_inst_valid", inst_valid, 1'b0);
        chk("async_rst_inst", inst, 32'h0);
        chk("async_rst_inst_pc", inst_pc, 32'h0);
        chk1("async_rst_inst_err", inst_err, 1'b0);
        do_reset();
        npops = 0;
        repeat (10) step(1, 1, 0, '0, 0);
        chk("post_rst_first_pc", first_pc, B);

        // Random traffic against the stream model, including wrap-around targets.
        do_reset();
        npops = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, t, int'($urandom_range(0, 3)));
        end
        chk1("random_progress", npops > 200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_25040105_ifu_prefetch.md
# ysyx_25040105_ifu_prefetch

Handshaked, parametrised instruction-fetch unit with a prefetch buffer. It is the multi-cycle successor to the single-cycle fetch path. It issues word fetches over a valid/ready request channel, takes responses of arbitrary latency, and queues {pc, inst, err} entries in a DEPTH-entry FIFO for the decoder. On a jump or branch redirect it flushes queued and in-flight fetches and restarts from the new PC.

## Interface
- XLEN, 32, address/data width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  out  1  fetch request valid
- req_addr  out  XLEN  fetch address, word-aligned
- req_ready  in  1  memory accepts request
- rsp_valid  in  1  fetch response valid (always accepted)
- rsp_data  in  32  fetched instruction word
- rsp_err  in  1  access fault on this fetch
- inst_valid  out  1  FIFO head valid
- inst  out  32  FIFO head instruction
- inst_pc  out  XLEN  FIFO head PC
- inst_err  out  1  FIFO head fault flag
- inst_ready  in  1  decoder consumes head
- redirect_en  in  1  jump/branch taken, flush and restart
- redirect_pc  in  XLEN  restart address

## Operation
- States: FETCH (req_valid=1), WAIT (one request in flight), DROP (in-flight response to be discarded). Only one outstanding request at a time.
- FETCH: req_valid = (count + 0) < DEPTH, i.e. space for the eventual response. req_addr = fetch_pc. On req_valid&req_ready: fetch_pc += 4, go to WAIT.
- WAIT: on rsp_valid, push {fetch_pc-4, rsp_data, rsp_err}, go to FETCH. Space is guaranteed by the FETCH check.
- DROP: on rsp_valid, discard the response, go to FETCH.
- rsp_valid in FETCH is ignored.
- Pop: inst_valid & inst_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect has priority over everything in that cycle:
  - FIFO cleared (a simultaneous pop or push is discarded).
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - If in WAIT without a same-cycle rsp_valid, or if a request handshake occurs in the same cycle, the next state is DROP. Otherwise the next state is FETCH.
- A second redirect while in DROP updates fetch_pc and stays in DROP.
- Arithmetic: fetch_pc wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- count is $clog2(DEPTH)+1 bits wide. Read and write pointers wrap modulo DEPTH.
- A faulting fetch (rsp_err=1) is queued normally with inst_err=1. Fetching continues; the decoder decides what to do with the fault.

## Timing
- Reset values: state FETCH, fetch_pc=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0, inst_err=0.
- req_valid is forced to 0 while rst is high. In the first cycle after deassertion, req_valid=1 and req_addr=RESET_PC.
- Reset mid-transaction abandons any outstanding response. The memory model must drop it as well.
- Response accepted at edge N gives inst_valid=1 in cycle N+1. There is no combinational rsp-to-inst bypass.
- All outputs come from registers only, with one exception: req_valid depends only on state and count.
- Throughput with a zero-wait memory (ready=1, response one cycle after request): one instruction per 2 cycles.
- Redirect at edge N:
  - inst_valid=0 in cycle N+1.
  - req_addr=redirect_pc in cycle N+1 if the next state is FETCH.
  - Otherwise req_addr=redirect_pc in the cycle after the dropped response arrives.
- Full: with count=DEPTH, req_valid=0 until a pop occurs. Empty: inst_valid=0.

## Structure
- Package ysyx_25040105_pkg holds:
  - the default RESET_PC constant;
  - the fetch state enum {FETCH, WAIT, DROP};
  - the struct ifq_entry_t {pc, inst, err}.
- Sub-module ysyx_25040105_fifo: parametrised synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Asynchronous active-high reset.
  - flush has priority over push and pop.
- The top level holds the FSM, fetch_pc and request/response logic, and instantiates one FIFO of ifq_entry_t.

## Test plan
- Reset, zero-wait memory returning addr^32'hA5A5_0000, inst_ready=1 → inst_pc sequence 0x8000_0000, 0x8000_0004, … with inst_valid every second cycle and matching inst.
- inst_ready=0 with DEPTH=4 → exactly 4 entries queued, req_valid=0 afterwards. Raising inst_ready → entries drain in order and fetching resumes at 0x8000_0010.
- Memory with 3-cycle response latency; redirect_pc=0x8000_0100 asserted 1 cycle after the request handshake → the in-flight response is discarded, the next req_addr is 0x8000_0100, and the first inst_pc out is 0x8000_0100.
- Redirect in the same cycle as a push and a pop → FIFO empty next cycle, count=0, no stale inst_valid.
- rsp_err=1 on the fetch at 0x8000_0008 → that entry has inst_err=1, neighbouring entries have inst_err=0, and fetching continues at 0x8000_000C.
- rst pulsed asynchronously while in WAIT → all outputs return to reset values immediately, and fetch restarts at RESET_PC after deassertion.
